// File: rtl/sdp_csr_regfile.sv
// sdp_csr_regfile: CSR slave for the SDP stage.
// Takes write and read requests on the csb2csr stream. The address is already rebased to 0.
// Returns read data on the csr2csb response. Holds the SDP configuration registers.
// Generates the op_start pulse, tracks busy/done/err status and drives a level interrupt.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   csr_req_vld/rdy  request handshake; master holds vld until rdy
//   csr_req_pd       {wr_rd, wdata[31:0], addr[ADDR_W-1:0]}; wr_rd=1 is a write
//   csr_resp_vld     one-cycle read response strobe
//   csr_resp_pd      read data, held until the next read response
//   op_start         one-cycle start pulse to the SDP datapath
//   op_done          one-cycle completion pulse from the SDP datapath
//   op_cfg           config registers 4..REG_NUM-1; reg k at [(k-4)*32 +: 32]
//   irq              registered level interrupt
//
// Register map (word address):
//   0 CTRL     W: bit0=1 requests a start; reads 0
//   1 STATUS   R: {err, done, busy}; W1C on done/err
//   2 INT_EN   RW [1:0] = {err_en, done_en}
//   3 VERSION  RO
//   4..        CFG, RW 32 bits
//   >=REG_NUM  writes ignored, reads return 0

module sdp_csr_regfile #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned REG_NUM = 32,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_req_vld,
  output logic                      csr_req_rdy,
  input  logic [ADDR_W+32:0]        csr_req_pd,
  output logic                      csr_resp_vld,
  output logic [31:0]               csr_resp_pd,
  output logic                      op_start,
  input  logic                      op_done,
  output logic [(REG_NUM-4)*32-1:0] op_cfg,
  output logic                      irq
);

  localparam int unsigned CfgNum = REG_NUM - 4;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        resp_vld_q, resp_vld_d;
  logic [31:0] resp_pd_q, resp_pd_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  int_en_q, int_en_d;
  logic        irq_q, irq_d;
  logic [31:0] cfg_q [CfgNum];
  logic [31:0] cfg_d [CfgNum];

  // Request decode
  logic              req_wr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       addr_ext;
  logic              in_range;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              start_req;
  logic [31:0]       rdata;

  assign req_wr    = csr_req_pd[ADDR_W+32];
  assign req_wdata = csr_req_pd[ADDR_W+31:ADDR_W];
  assign req_addr  = csr_req_pd[ADDR_W-1:0];
  // Full-width compare so that out-of-window addresses never alias onto real registers.
  assign addr_ext  = 32'(req_addr);
  assign in_range  = addr_ext < REG_NUM;

  // rdy is registered, so it is low in the first cycle after reset and during StResp.
  assign accept = csr_req_vld & rdy_q;
  assign wr_acc = accept & req_wr;
  assign rd_acc = accept & ~req_wr;

  // Read mux samples pre-update register state.
  always_comb begin
    rdata = 32'h0;
    if (in_range) begin
      if (addr_ext == 32'd1) begin
        rdata = {29'h0, err_q, done_q, busy_q};
      end else if (addr_ext == 32'd2) begin
        rdata = {30'h0, int_en_q};
      end else if (addr_ext == 32'd3) begin
        rdata = VERSION;
      end else begin
        for (int unsigned k = 0; k < CfgNum; k++) begin
          if (addr_ext == k + 32'd4) rdata = cfg_q[k];
        end
      end
    end
  end

  // FSM and register next-state
  always_comb begin
    state_d    = state_q;
    resp_vld_d = 1'b0;
    resp_pd_d  = resp_pd_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    int_en_d   = int_en_q;
    cfg_d      = cfg_q;
    start_req  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_acc) begin
          state_d    = StResp;
          resp_vld_d = 1'b1;
          resp_pd_d  = rdata;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    rdy_d = (state_d == StIdle);

    if (wr_acc && in_range) begin
      if (addr_ext == 32'd0) begin
        start_req = req_wdata[0];
      end else if (addr_ext == 32'd1) begin
        if (req_wdata[1]) done_d = 1'b0;
        if (req_wdata[2]) err_d  = 1'b0;
      end else if (addr_ext == 32'd2) begin
        int_en_d = req_wdata[1:0];
      end else begin
        for (int unsigned k = 0; k < CfgNum; k++) begin
          if (addr_ext == k + 32'd4) cfg_d[k] = req_wdata;
        end
      end
    end

    // Set events come after W1C so a same-cycle set wins.
    if (op_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      if (!busy_q) err_d = 1'b1;
    end

    // Start is judged on registered busy; a same-cycle op_done does not free the engine.
    if (start_req) begin
      if (!busy_q) begin
        start_d = 1'b1;
        busy_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    irq_d = (done_q & int_en_q[0]) | (err_q & int_en_q[1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rdy_q      <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_pd_q  <= 32'h0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      int_en_q   <= 2'b00;
      irq_q      <= 1'b0;
      for (int unsigned k = 0; k < CfgNum; k++) cfg_q[k] <= 32'h0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      resp_vld_q <= resp_vld_d;
      resp_pd_q  <= resp_pd_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      int_en_q   <= int_en_d;
      irq_q      <= irq_d;
      cfg_q      <= cfg_d;
    end
  end

  assign csr_req_rdy  = rdy_q;
  assign csr_resp_vld = resp_vld_q;
  assign csr_resp_pd  = resp_pd_q;
  assign op_start     = start_q;
  assign irq          = irq_q;

  for (genvar g = 0; g < CfgNum; g++) begin : g_cfg
    assign op_cfg[g*32 +: 32] = cfg_q[g];
  end

endmodule

// File: tb/tb_sdp_csr_regfile.sv
module tb_sdp_csr_regfile;

  localparam int ADDR_W  = 8;
  localparam int REG_NUM = 32;
  localparam int PD_W    = ADDR_W + 33;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      vld;
  logic                      rdy;
  logic [PD_W-1:0]           pd;
  logic                      resp_vld;
  logic [31:0]               resp_pd;
  logic                      op_start;
  logic                      op_done;
  logic [(REG_NUM-4)*32-1:0] op_cfg;
  logic                      irq;

  int n_pass  = 0;
  int n_total = 0;
  int start_cnt = 0;
  int resp_cnt  = 0;
  int s0;
  int r0;

  sdp_csr_regfile #(
    .ADDR_W (ADDR_W),
    .REG_NUM(REG_NUM),
    .VERSION(VER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_req_vld (vld),
    .csr_req_rdy (rdy),
    .csr_req_pd  (pd),
    .csr_resp_vld(resp_vld),
    .csr_resp_pd (resp_pd),
    .op_start    (op_start),
    .op_done     (op_done),
    .op_cfg      (op_cfg),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (op_start === 1'b1) start_cnt <= start_cnt + 1;
    if (resp_vld === 1'b1) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with vld already driven; returns when the next posedge accepts.
  task automatic wait_rdy(input string tag);
    int n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_rdy_timeout"}, 32'(rdy), 32'd1);
  endtask

  task automatic csr_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    vld = 1'b1;
    pd  = {1'b1, d, a};
    wait_rdy("wr");
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic csr_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    vld = 1'b1;
    pd  = {1'b0, 32'h0, a};
    wait_rdy(tag);
    @(negedge clk);
    vld = 1'b0;
    chk({tag, "_vld"}, 32'(resp_vld), 32'd1);
    chk(tag, resp_pd, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_vld), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    vld     = 1'b0;
    pd      = '0;
    op_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_resp_vld", 32'(resp_vld), 32'd0);
    chk("rst_resp_pd", resp_pd, 32'h0);
    chk("rst_op_start", 32'(op_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cfg4", op_cfg[31:0], 32'h0);
    rst_n = 1'b1;

    // 1: config register write/read, op_cfg mapping, INT_EN width
    csr_write(8'd4, 32'hA5A5_0001);
    chk("cfg4_drive", op_cfg[31:0], 32'hA5A5_0001);
    csr_read(8'd4, 32'hA5A5_0001, "rd_cfg4");
    csr_write(8'd31, 32'h1234_5678);
    chk("cfg31_drive", op_cfg[27*32 +: 32], 32'h1234_5678);
    csr_read(8'd31, 32'h1234_5678, "rd_cfg31");
    csr_write(8'd2, 32'hFFFF_FFFF);
    csr_read(8'd2, 32'h0000_0003, "rd_int_en_mask");
    csr_write(8'd2, 32'h0);
    csr_read(8'd0, 32'h0, "rd_ctrl");

    // 2: VERSION read-only, out-of-range addresses
    csr_read(8'd3, VER, "rd_version");
    csr_write(8'd3, 32'h0);
    csr_read(8'd3, VER, "rd_version_ro");
    r0 = resp_cnt;
    csr_read(8'd200, 32'h0, "rd_addr200");
    chk("addr200_one_resp", 32'(resp_cnt - r0), 32'd1);
    csr_write(8'd32, 32'hDEAD_BEEF);
    csr_read(8'd32, 32'h0, "rd_addr32");

    // 3: start, done, irq, W1C
    csr_write(8'd2, 32'h1);
    s0 = start_cnt;
    csr_write(8'd0, 32'h1);
    chk("start_pulse_hi", 32'(op_start), 32'd1);
    @(negedge clk);
    chk("start_pulse_lo", 32'(op_start), 32'd0);
    chk("start_count1", 32'(start_cnt - s0), 32'd1);
    csr_read(8'd1, 32'h1, "status_busy");
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    csr_read(8'd1, 32'h2, "status_done");
    chk("irq_done", 32'(irq), 32'd1);
    csr_write(8'd1, 32'h2);
    csr_read(8'd1, 32'h0, "status_w1c");
    chk("irq_cleared", 32'(irq), 32'd0);

    // 4: start while busy is rejected and flags err
    s0 = start_cnt;
    csr_write(8'd0, 32'h1);
    csr_write(8'd0, 32'h1);
    csr_read(8'd1, 32'h5, "status_busy_err");
    chk("start_count_once", 32'(start_cnt - s0), 32'd1);
    chk("irq_err_masked", 32'(irq), 32'd0);
    csr_write(8'd2, 32'h2);
    @(negedge clk);
    chk("irq_err", 32'(irq), 32'd1);

    // 5: W1C done in the same cycle as op_done; done stays set
    @(negedge clk);
    vld     = 1'b1;
    pd      = {1'b1, 32'h2, 8'd1};
    op_done = 1'b1;
    chk("w1c_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    vld     = 1'b0;
    op_done = 1'b0;
    csr_read(8'd1, 32'h6, "status_set_wins");
    chk("irq_still", 32'(irq), 32'd1);

    // Request held through the response cycle is not accepted twice
    r0 = resp_cnt;
    @(negedge clk);
    vld = 1'b1;
    pd  = {1'b0, 32'h0, 8'd4};
    wait_rdy("hold");
    @(negedge clk);
    chk("hold_resp_vld", 32'(resp_vld), 32'd1);
    chk("hold_rdy_low", 32'(rdy), 32'd0);
    chk("hold_pd1", resp_pd, 32'hA5A5_0001);
    pd = {1'b0, 32'h0, 8'd3};
    @(negedge clk);
    chk("hold_resp_gap", 32'(resp_vld), 32'd0);
    chk("hold_rdy_back", 32'(rdy), 32'd1);
    chk("hold_pd_stable", resp_pd, 32'hA5A5_0001);
    chk("hold_one_resp", 32'(resp_cnt - r0), 32'd1);
    @(negedge clk);
    vld = 1'b0;
    chk("hold_resp2_vld", 32'(resp_vld), 32'd1);
    chk("hold_pd2", resp_pd, VER);
    @(negedge clk);
    chk("hold_two_resp", 32'(resp_cnt - r0), 32'd2);

    // 6: reset during the response cycle
    @(negedge clk);
    vld = 1'b1;
    pd  = {1'b0, 32'h0, 8'd4};
    wait_rdy("rst_mid");
    @(negedge clk);
    chk("pre_rst_resp_vld", 32'(resp_vld), 32'd1);
    rst_n = 1'b0;
    vld   = 1'b0;
    @(negedge clk);
    chk("mid_rst_resp_vld", 32'(resp_vld), 32'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'd0);
    chk("mid_rst_cfg4", op_cfg[31:0], 32'h0);
    chk("mid_rst_cfg31", op_cfg[27*32 +: 32], 32'h0);
    chk("mid_rst_resp_pd", resp_pd, 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    csr_read(8'd1, 32'h0, "post_rst_status");
    csr_read(8'd2, 32'h0, "post_rst_int_en");
    csr_read(8'd4, 32'h0, "post_rst_cfg4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
